// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised symbol-sequence detector.
// Samples one DATA_W-bit symbol per enabled clock and pulses seq_found for one
// cycle when the last SEQ_LEN enabled symbols equal the pattern. Provides
// overlap / non-overlap matching, synchronous clear and a saturating match count.
// Optional build macro SEQ_DET_PROG_PATTERN_EN: adds a runtime-writable pattern
// register (pat_wr_en / pat_wr_idx / pat_wr_data); otherwise PATTERN is fixed.
module seq_detector_param #(
    parameter int                           DATA_W  = 3,
    parameter int                           SEQ_LEN = 8,
    parameter logic [DATA_W*SEQ_LEN-1:0]    PATTERN = 24'hAF61A9,
    parameter int                           CNT_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [DATA_W-1:0]           data,
    input  logic                        overlap,
    input  logic                        clear,
`ifdef SEQ_DET_PROG_PATTERN_EN
    input  logic                        pat_wr_en,
    input  logic [$clog2(SEQ_LEN)-1:0]  pat_wr_idx,
    input  logic [DATA_W-1:0]           pat_wr_data,
`endif
    output logic                        seq_found,
    output logic [CNT_W-1:0]            match_count,
    output logic                        count_sat
);

    localparam int                FILL_W   = $clog2(SEQ_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_LEN - 1);

    // hist[0] is the most recent symbol; only SEQ_LEN-1 are kept because the
    // final symbol of the window is always the live data input.
    logic [DATA_W-1:0]          hist [SEQ_LEN-1];
    logic [FILL_W-1:0]          fill;
    logic [DATA_W*SEQ_LEN-1:0]  window;
    logic [DATA_W*SEQ_LEN-1:0]  pattern_cur;
    logic                       pat_wr_hit;
    logic                       match_now;
    logic                       shift_en;
    logic [FILL_W-1:0]          fill_nxt;
    logic                       found_nxt;
    logic [CNT_W-1:0]           cnt_nxt;

`ifdef SEQ_DET_PROG_PATTERN_EN
    logic [DATA_W-1:0] pat_mem [SEQ_LEN];

    assign pat_wr_hit = pat_wr_en && (32'(pat_wr_idx) < SEQ_LEN);

    // Pattern register: reloads PATTERN on reset, single-entry writes afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SEQ_LEN; k++) begin
                pat_mem[k] <= PATTERN[k*DATA_W +: DATA_W];
            end
        end else if (pat_wr_hit) begin
            pat_mem[pat_wr_idx] <= pat_wr_data;
        end
    end

    // Pack the pattern register into the same layout as the constant.
    always_comb begin
        pattern_cur = '0;
        for (int k = 0; k < SEQ_LEN; k++) begin
            pattern_cur[k*DATA_W +: DATA_W] = pat_mem[k];
        end
    end
`else
    assign pat_wr_hit  = 1'b0;
    assign pattern_cur = PATTERN;
`endif

    // Window symbol k: oldest history first, live data as the last symbol.
    always_comb begin
        window = '0;
        for (int k = 0; k < SEQ_LEN - 1; k++) begin
            window[k*DATA_W +: DATA_W] = hist[SEQ_LEN-2-k];
        end
        window[(SEQ_LEN-1)*DATA_W +: DATA_W] = data;
    end

    assign match_now = enable && !clear && (fill == FILL_MAX) && (window == pattern_cur);
    assign count_sat = (match_count == {CNT_W{1'b1}});

    // Next-state decode: clear beats enable; a pattern write restarts the fill.
    always_comb begin
        fill_nxt  = fill;
        found_nxt = 1'b0;
        cnt_nxt   = match_count;
        shift_en  = 1'b0;
        if (clear) begin
            fill_nxt = '0;
            cnt_nxt  = '0;
        end else if (enable) begin
            shift_en = 1'b1;
            if (match_now) begin
                found_nxt = 1'b1;
                if (!count_sat) begin
                    cnt_nxt = match_count + CNT_W'(1);
                end
                fill_nxt = overlap ? FILL_MAX : '0;
            end else if (fill != FILL_MAX) begin
                fill_nxt = fill + FILL_W'(1);
            end
        end
        if (pat_wr_hit) begin
            fill_nxt = '0;
        end
    end

    // Control registers: fill level, match pulse and match counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill        <= '0;
            seq_found   <= 1'b0;
            match_count <= '0;
        end else begin
            fill        <= fill_nxt;
            seq_found   <= found_nxt;
            match_count <= cnt_nxt;
        end
    end

    // Symbol history shift register, advanced on every enabled, uncleared symbol.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SEQ_LEN - 1; k++) begin
                hist[k] <= '0;
            end
        end else if (shift_en) begin
            hist[0] <= data;
            for (int k = 1; k < SEQ_LEN - 1; k++) begin
                hist[k] <= hist[k-1];
            end
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param (default build, fixed pattern).
// dut0: default parameters. dut1: DATA_W=1, SEQ_LEN=3, PATTERN=101, CNT_W=2.
// Reference model keeps a queue of enabled symbols since the last flush.
module tb_seq_detector_param;

    logic       clk;
    logic       rst_n;
    logic       en0, ov0, clr0;
    logic [2:0] data0;
    logic       found0, sat0;
    logic [7:0] cnt0;
    logic       en1, ov1, clr1;
    logic [0:0] data1;
    logic       found1, sat1;
    logic [1:0] cnt1;

    int n_checks = 0;
    int n_pass   = 0;

    int pat0 [8] = '{1, 5, 6, 0, 6, 6, 3, 5};
    int pat1 [3] = '{1, 0, 1};
    int q0 [$];
    int q1 [$];
    bit ef0, ef1;
    int ec0, ec1;

    seq_detector_param dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en0), .data(data0), .overlap(ov0),
        .clear(clr0), .seq_found(found0), .match_count(cnt0), .count_sat(sat0)
    );

    seq_detector_param #(.DATA_W(1), .SEQ_LEN(3), .PATTERN(3'b101), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en1), .data(data1), .overlap(ov1),
        .clear(clr1), .seq_found(found1), .match_count(cnt1), .count_sat(sat1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        q0.delete(); q1.delete();
        ef0 = 0; ef1 = 0; ec0 = 0; ec1 = 0;
    endtask

    // Drive both DUTs for one edge and advance the reference model.
    task automatic tick(input logic e0, input logic [2:0] x0, input logic o0, input logic c0,
                        input logic e1, input logic x1, input logic o1, input logic c1);
        bit hit;
        @(negedge clk);
        en0 = e0; data0 = x0; ov0 = o0; clr0 = c0;
        en1 = e1; data1 = x1; ov1 = o1; clr1 = c1;
        if (c0) begin
            q0.delete(); ef0 = 0; ec0 = 0;
        end else if (!e0) begin
            ef0 = 0;
        end else begin
            q0.push_back(int'(x0));
            hit = (q0.size() >= 8);
            for (int k = 0; k < 8; k++)
                if (hit && q0[q0.size()-8+k] != pat0[k]) hit = 0;
            ef0 = hit;
            if (hit) begin
                if (ec0 < 255) ec0++;
                if (!o0) q0.delete();
            end
            if (q0.size() > 8) void'(q0.pop_front());
        end
        if (c1) begin
            q1.delete(); ef1 = 0; ec1 = 0;
        end else if (!e1) begin
            ef1 = 0;
        end else begin
            q1.push_back(int'(x1));
            hit = (q1.size() >= 3);
            for (int k = 0; k < 3; k++)
                if (hit && q1[q1.size()-3+k] != pat1[k]) hit = 0;
            ef1 = hit;
            if (hit) begin
                if (ec1 < 3) ec1++;
                if (!o1) q1.delete();
            end
            if (q1.size() > 3) void'(q1.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step0(input logic e, input int d, input logic o, input logic c);
        tick(e, 3'(d), o, c, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step1(input logic e, input int d, input logic o, input logic c);
        tick(1'b0, 3'd0, 1'b0, 1'b0, e, 1'(d), o, c);
    endtask

    task automatic test_reset();
        en0 = 0; data0 = 0; ov0 = 0; clr0 = 0;
        en1 = 0; data1 = 0; ov1 = 0; clr1 = 0;
        rst_n = 1'b0;
        model_reset();
        #12;
        n_checks++; if (found0 !== 1'b0) $display("FAIL reset_found0 got %0b exp 0", found0); else n_pass++;
        n_checks++; if (cnt0 !== 8'd0) $display("FAIL reset_cnt0 got %0d exp 0", cnt0); else n_pass++;
        n_checks++; if (sat0 !== 1'b0) $display("FAIL reset_sat0 got %0b exp 0", sat0); else n_pass++;
        n_checks++; if (found1 !== 1'b0 || cnt1 !== 2'd0 || sat1 !== 1'b0)
            $display("FAIL reset_dut1 got found=%0b cnt=%0d sat=%0b exp 0/0/0", found1, cnt1, sat1);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_pattern();
        for (int i = 0; i < 8; i++) begin
            step0(1, pat0[i], 0, 0);
            n_checks++;
            if (found0 !== (i == 7)) $display("FAIL pattern_found sym %0d got %0b exp %0b", i, found0, (i == 7));
            else n_pass++;
        end
        step0(0, 0, 0, 0);
        n_checks++; if (found0 !== 1'b0) $display("FAIL pattern_pulse_width got %0b exp 0", found0); else n_pass++;
        n_checks++; if (cnt0 !== 8'd1) $display("FAIL pattern_count got %0d exp 1", cnt0); else n_pass++;
    endtask

    task automatic test_mismatch();
        int bad [3] = '{1, 5, 7};
        step0(0, 0, 0, 1);
        n_checks++; if (cnt0 !== 8'd0) $display("FAIL mismatch_clear_cnt got %0d exp 0", cnt0); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step0(1, bad[i], 0, 0);
            n_checks++;
            if (found0 !== 1'b0 || cnt0 !== 8'd0)
                $display("FAIL mismatch_prefix sym %0d got found=%0b cnt=%0d exp 0/0", i, found0, cnt0);
            else n_pass++;
        end
        for (int i = 0; i < 8; i++) begin
            step0(1, pat0[i], 0, 0);
            n_checks++;
            if (found0 !== (i == 7)) $display("FAIL mismatch_then_match sym %0d got %0b exp %0b", i, found0, (i == 7));
            else n_pass++;
        end
        n_checks++; if (cnt0 !== 8'd1) $display("FAIL mismatch_count got %0d exp 1", cnt0); else n_pass++;
    endtask

    task automatic test_enable_gaps();
        for (int i = 0; i < 4; i++) begin
            step0(1, pat0[i], 0, 0);
            n_checks++; if (found0 !== 1'b0) $display("FAIL gaps_head sym %0d got %0b exp 0", i, found0); else n_pass++;
        end
        for (int g = 0; g < 3; g++) begin
            step0(0, $urandom_range(0, 7), 0, 0);
            n_checks++; if (found0 !== 1'b0) $display("FAIL gaps_idle cyc %0d got %0b exp 0", g, found0); else n_pass++;
        end
        for (int i = 4; i < 8; i++) begin
            step0(1, pat0[i], 0, 0);
            n_checks++;
            if (found0 !== (i == 7)) $display("FAIL gaps_tail sym %0d got %0b exp %0b", i, found0, (i == 7));
            else n_pass++;
        end
        n_checks++; if (cnt0 !== 8'd2) $display("FAIL gaps_count got %0d exp 2", cnt0); else n_pass++;
    endtask

    task automatic test_overlap();
        int s [5] = '{1, 0, 1, 0, 1};
        for (int mode = 1; mode >= 0; mode--) begin
            step1(0, 0, 0, 1);
            for (int i = 0; i < 5; i++) begin
                step1(1, s[i], 1'(mode), 0);
                n_checks++;
                if (found1 !== ((i == 2) || (mode == 1 && i == 4)))
                    $display("FAIL overlap%0d_found sym %0d got %0b exp %0b", mode, i, found1,
                             ((i == 2) || (mode == 1 && i == 4)));
                else n_pass++;
            end
            n_checks++;
            if (cnt1 !== ((mode == 1) ? 2'd2 : 2'd1))
                $display("FAIL overlap%0d_count got %0d exp %0d", mode, cnt1, (mode == 1) ? 2 : 1);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        int tail [3] = '{1, 0, 1};
        step1(0, 0, 1, 1);
        for (int i = 0; i < 9; i++) begin
            step1(1, (i % 2 == 0) ? 1 : 0, 1, 0);
            n_checks++;
            if (found1 !== (i % 2 == 0 && i > 0))
                $display("FAIL sat_found sym %0d got %0b exp %0b", i, found1, (i % 2 == 0 && i > 0));
            else n_pass++;
        end
        n_checks++; if (cnt1 !== 2'd3) $display("FAIL sat_count got %0d exp 3", cnt1); else n_pass++;
        n_checks++; if (sat1 !== 1'b1) $display("FAIL sat_flag got %0b exp 1", sat1); else n_pass++;
        step1(1, 1, 1, 0);
        step1(1, 0, 1, 0);
        step1(1, 1, 1, 1);
        n_checks++;
        if (found1 !== 1'b0 || cnt1 !== 2'd0 || sat1 !== 1'b0)
            $display("FAIL sat_clear got found=%0b cnt=%0d sat=%0b exp 0/0/0", found1, cnt1, sat1);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step1(1, tail[i], 1, 0);
            n_checks++;
            if (found1 !== (i == 2)) $display("FAIL sat_refill sym %0d got %0b exp %0b", i, found1, (i == 2));
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) step0(1, pat0[i], 0, 0);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (found0 !== 1'b0 || cnt0 !== 8'd0 || sat0 !== 1'b0)
            $display("FAIL async_rst got found=%0b cnt=%0d sat=%0b exp 0/0/0", found0, cnt0, sat0);
        else n_pass++;
        n_checks++; if (cnt1 !== 2'd0) $display("FAIL async_rst_dut1 cnt got %0d exp 0", cnt1); else n_pass++;
        rst_n = 1'b1;
        for (int i = 5; i < 8; i++) begin
            step0(1, pat0[i], 0, 0);
            n_checks++; if (found0 !== 1'b0) $display("FAIL async_partial sym %0d got %0b exp 0", i, found0); else n_pass++;
        end
        for (int i = 0; i < 8; i++) begin
            step0(1, pat0[i], 0, 0);
            n_checks++;
            if (found0 !== (i == 7)) $display("FAIL async_full sym %0d got %0b exp %0b", i, found0, (i == 7));
            else n_pass++;
        end
        n_checks++; if (cnt0 !== 8'd1) $display("FAIL async_count got %0d exp 1", cnt0); else n_pass++;
    endtask

    task automatic test_random();
        int   kpos = 0;
        logic o0 = 1'b0;
        logic o1 = 1'b1;
        logic e0, e1, c0, c1;
        int   d0, d1;
        for (int n = 0; n < 800; n++) begin
            e0 = ($urandom_range(0, 3) != 0);
            e1 = ($urandom_range(0, 3) != 0);
            c0 = ($urandom_range(0, 99) == 0);
            c1 = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 15) == 0) o0 = ~o0;
            if ($urandom_range(0, 7) == 0) o1 = ~o1;
            d0 = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : pat0[kpos];
            if (e0) kpos = (kpos + 1) % 8;
            d1 = int'($urandom_range(0, 1));
            tick(e0, 3'(d0), o0, c0, e1, 1'(d1), o1, c1);
            n_checks++;
            if (found0 !== ef0 || cnt0 !== 8'(ec0) || sat0 !== (ec0 == 255))
                $display("FAIL rand_dut0 cyc %0d got found=%0b cnt=%0d sat=%0b exp %0b/%0d/%0b",
                         n, found0, cnt0, sat0, ef0, ec0, (ec0 == 255));
            else n_pass++;
            n_checks++;
            if (found1 !== ef1 || cnt1 !== 2'(ec1) || sat1 !== (ec1 == 3))
                $display("FAIL rand_dut1 cyc %0d got found=%0b cnt=%0d sat=%0b exp %0b/%0d/%0b",
                         n, found1, cnt1, sat1, ef1, ec1, (ec1 == 3));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_mismatch();
        test_enable_gaps();
        test_overlap();
        test_saturation();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
